// File: rtl/yarp_pkg.sv
// Shared types for the YARP memory arbiter slice: bus owner IDs and arbiter FSM states.
package yarp_pkg;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } mem_owner_t;

  typedef enum logic {
    ARB_IDLE     = 1'b0,
    ARB_WAIT_GNT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/yarp_tag_fifo.sv
// In-order owner-tag FIFO: remembers who issued each read so returns can be routed back.
module yarp_tag_fifo
  import yarp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  mem_owner_t din,
  output mem_owner_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_owner_t    mem_q [DEPTH];
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    empty   = (cnt_q == '0);
    dout    = mem_q[rd_q];
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? bump(wr_q) : wr_q;
    rd_d    = do_pop ? bump(rd_q) : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/yarp_mem_arb.sv
// Two-master (fetch/data) arbiter onto one memory port with starvation guard
// and an in-order tag FIFO that steers read returns back to their issuer.
module yarp_mem_arb
  import yarp_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned STARVE_MAX  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        imem_req_i,
  input  logic [31:0] imem_addr_i,
  output logic        imem_gnt_o,
  output logic        imem_rvalid_o,
  output logic [31:0] imem_rdata_o,
  input  logic        dmem_req_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic        dmem_gnt_o,
  output logic        dmem_rvalid_o,
  output logic [31:0] dmem_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_t state_q, state_d;
  mem_owner_t owner_q, owner_d, sel, owner, tag_out;
  logic [2:0] starve_q, starve_d;
  logic       err_q, err_d;
  logic       fifo_full, fifo_empty, push, pop, hs, rv_ok;

  // Owner choice and request issue; the full check only blocks reads.
  always_comb begin
    sel = OWN_DMEM;
    if (imem_req_i && (!dmem_req_i || starve_q == STARVE_LIM)) sel = OWN_IMEM;
    owner     = (state_q == ARB_WAIT_GNT) ? owner_q : sel;
    mem_req_o = 1'b0;
    if (reset_n) begin
      if (state_q == ARB_WAIT_GNT) mem_req_o = 1'b1;
      else if (imem_req_i || dmem_req_i)
        mem_req_o = ((sel == OWN_DMEM) && dmem_we_i) || !fifo_full;
    end
    hs = mem_req_o && mem_gnt_i;
  end

  always_comb begin
    mem_we_o    = mem_req_o && (owner == OWN_DMEM) && dmem_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      mem_addr_o = (owner == OWN_DMEM) ? dmem_addr_i : imem_addr_i;
      if (owner == OWN_DMEM) mem_wdata_o = dmem_wdata_i;
    end
    imem_gnt_o    = hs && (owner == OWN_IMEM);
    dmem_gnt_o    = hs && (owner == OWN_DMEM);
    push          = hs && !mem_we_o;
    pop           = reset_n && mem_rvalid_i;
    rv_ok         = pop && !fifo_empty;
    imem_rvalid_o = rv_ok && (tag_out == OWN_IMEM);
    dmem_rvalid_o = rv_ok && (tag_out == OWN_DMEM);
    imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : '0;
    dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;
    err_o         = err_q;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    err_d    = err_q || (pop && fifo_empty);
    if (state_q == ARB_IDLE) begin
      if (mem_req_o && !mem_gnt_i) begin
        state_d = ARB_WAIT_GNT;
        owner_d = sel;
      end
    end else if (mem_gnt_i) begin
      state_d = ARB_IDLE;
    end
    if (!imem_req_i || imem_gnt_o) starve_d = '0;
    else if (dmem_gnt_o && starve_q != STARVE_LIM) starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IMEM;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  yarp_tag_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_tag_fifo (
    .clk  (clk),
    .rst_n(reset_n),
    .push (push),
    .pop  (pop),
    .din  (owner),
    .dout (tag_out),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_yarp_mem_arb.sv
// Random + directed bench for yarp_mem_arb: per-requestor read-data scoreboards
// plus a queue-based arbitration reference model evaluated every cycle.
module tb_yarp_mem_arb;
  import yarp_pkg::*;

  localparam int unsigned OUTST  = 2;
  localparam int unsigned STARVE = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_i = 1'b0, dmem_req_i = 1'b0, dmem_we_i = 1'b0;
  logic [31:0] imem_addr_i = '0, dmem_addr_i = '0, dmem_wdata_i = '0;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        imem_gnt_o, imem_rvalid_o, dmem_gnt_o, dmem_rvalid_o;
  logic        mem_req_o, mem_we_o, err_o;
  logic [31:0] imem_rdata_o, dmem_rdata_o, mem_addr_o, mem_wdata_o;

  yarp_mem_arb #(
    .OUTSTANDING(OUTST),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req_i   (imem_req_i),
    .imem_addr_i  (imem_addr_i),
    .imem_gnt_o   (imem_gnt_o),
    .imem_rvalid_o(imem_rvalid_o),
    .imem_rdata_o (imem_rdata_o),
    .dmem_req_i   (dmem_req_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_gnt_o   (dmem_gnt_o),
    .dmem_rvalid_o(dmem_rvalid_o),
    .dmem_rdata_o (dmem_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0, n_total = 0;

  logic [31:0] exp_i[$], exp_d[$], mem_q[$];
  bit          m_tags[$];
  bit          gseq[$];
  bit          m_wait = 0, m_own = 0, m_err = 0;
  int          m_starve = 0;
  bit          e_req, e_own, e_rd, e_hs, e_rv, e_rv_own;
  bit          auto_mem = 0, rec = 0, i_gnt_seen = 0, d_gnt_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rd_hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: reference arbitration model plus read-data scoreboards.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_ctrl", {mem_req_o, mem_we_o, imem_gnt_o, dmem_gnt_o,
                           imem_rvalid_o, dmem_rvalid_o, err_o}, 32'd0);
      check("reset_bus", mem_addr_o | mem_wdata_o | imem_rdata_o | dmem_rdata_o, 32'd0);
      m_wait = 0; m_starve = 0; m_err = 0;
      m_tags.delete();
    end else begin
      if (m_wait) begin
        e_own = m_own;
        e_rd  = !(e_own && dmem_we_i);
        e_req = 1;
      end else begin
        e_own = (dmem_req_i && !(m_starve == STARVE && imem_req_i)) ? 1'b1 : !imem_req_i;
        e_rd  = !(e_own && dmem_we_i);
        e_req = (imem_req_i || dmem_req_i) && (!e_rd || m_tags.size() < OUTST);
      end
      check("mem_req", mem_req_o, e_req);
      if (e_req) begin
        check("mem_addr", mem_addr_o, e_own ? dmem_addr_i : imem_addr_i);
        check("mem_we", mem_we_o, e_own && dmem_we_i);
        if (!e_own) check("mem_wdata_imem", mem_wdata_o, 32'd0);
        else if (dmem_we_i) check("mem_wdata", mem_wdata_o, dmem_wdata_i);
      end
      e_hs = e_req && mem_gnt_i;
      check("gnt_i_d", {imem_gnt_o, dmem_gnt_o}, {e_hs && !e_own, e_hs && e_own});
      e_rv     = mem_rvalid_i && m_tags.size() > 0;
      e_rv_own = e_rv ? m_tags[0] : 1'b0;
      check("rvalid_i_d", {imem_rvalid_o, dmem_rvalid_o}, {e_rv && !e_rv_own, e_rv && e_rv_own});
      check("err", err_o, m_err);

      if (!imem_rvalid_o) check("imem_rdata_idle", imem_rdata_o, 32'd0);
      else if (exp_i.size() == 0) begin
        n_total++;
        $display("FAIL imem_sb: rvalid with data %h, required no return", imem_rdata_o);
      end else check("imem_rdata", imem_rdata_o, exp_i.pop_front());
      if (!dmem_rvalid_o) check("dmem_rdata_idle", dmem_rdata_o, 32'd0);
      else if (exp_d.size() == 0) begin
        n_total++;
        $display("FAIL dmem_sb: rvalid with data %h, required no return", dmem_rdata_o);
      end else check("dmem_rdata", dmem_rdata_o, exp_d.pop_front());

      if (rec && (imem_gnt_o || dmem_gnt_o)) gseq.push_back(dmem_gnt_o);

      if (!imem_req_i || (e_hs && !e_own)) m_starve = 0;
      else if (e_hs && e_own && m_starve < STARVE) m_starve++;
      if (!m_wait && e_req && !mem_gnt_i) begin
        m_wait = 1;
        m_own  = e_own;
      end else if (e_hs) m_wait = 0;
      if (mem_rvalid_i) begin
        if (m_tags.size() == 0) m_err = 1;
        else void'(m_tags.pop_front());
      end
      if (e_hs && e_rd) m_tags.push_back(e_own);

      if (auto_mem && mem_req_o && mem_gnt_i && !mem_we_o) mem_q.push_back(rd_hash(mem_addr_o));
      if (imem_gnt_o) i_gnt_seen = 1;
      if (dmem_gnt_o) d_gnt_seen = 1;
    end
  end

  initial begin
    bit exp_seq[8];
    exp_seq = '{1, 1, 1, 0, 1, 1, 1, 0};

    // Requests and a stray rvalid during reset must not leak to outputs.
    imem_req_i = 1; dmem_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    repeat (3) step();
    reset_n = 1; imem_req_i = 0; dmem_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;

    auto_mem = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!imem_req_i || i_gnt_seen) begin
        imem_req_i = ($urandom_range(0, 9) < 6);
        if (imem_req_i) begin
          imem_addr_i = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
          exp_i.push_back(rd_hash(imem_addr_i));
        end
      end
      i_gnt_seen = 0;
      if (!dmem_req_i || d_gnt_seen) begin
        dmem_req_i = ($urandom_range(0, 9) < 6);
        if (dmem_req_i) begin
          dmem_we_i    = ($urandom_range(0, 2) == 0);
          dmem_addr_i  = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
          dmem_wdata_i = $urandom;
          if (!dmem_we_i) exp_d.push_back(rd_hash(dmem_addr_i));
        end
      end
      d_gnt_seen = 0;
      mem_gnt_i = ($urandom_range(0, 9) < 6);
      if (mem_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_rvalid_i = 1; mem_rdata_i = mem_q.pop_front();
      end else begin
        mem_rvalid_i = 0; mem_rdata_i = $urandom;
      end
    end

    for (int c = 0; c < 400; c++) begin
      step();
      if (i_gnt_seen) imem_req_i = 0;
      if (d_gnt_seen) dmem_req_i = 0;
      i_gnt_seen = 0; d_gnt_seen = 0;
      mem_gnt_i = ($urandom_range(0, 9) < 6);
      if (mem_q.size() > 0) begin
        mem_rvalid_i = 1; mem_rdata_i = mem_q.pop_front();
      end else begin
        mem_rvalid_i = 0; mem_rdata_i = $urandom;
      end
      if (!imem_req_i && !dmem_req_i && mem_q.size() == 0 && m_tags.size() == 0 && !mem_rvalid_i) break;
    end
    check("drain_imem_sb", exp_i.size(), 32'd0);
    check("drain_dmem_sb", exp_d.size(), 32'd0);
    auto_mem = 0;

    // Fetch read: grant same cycle, data next cycle.
    step(); mem_rvalid_i = 0; mem_gnt_i = 1;
    imem_req_i = 1; imem_addr_i = 32'h100; exp_i.push_back(32'hDEAD_BEEF);
    @(negedge clk); check("fetch_gnt_c0", imem_gnt_o, 32'd1);
    step(); imem_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk); check("fetch_rv_c1", {imem_rvalid_o, dmem_rvalid_o}, 32'd2);
    step(); mem_rvalid_i = 0;

    // Continuous contention: starvation guard order.
    imem_req_i = 1; imem_addr_i = 32'h1000_0040;
    dmem_req_i = 1; dmem_we_i = 1; dmem_addr_i = 32'h2000_0080; dmem_wdata_i = 32'h1357_9BDF;
    mem_gnt_i = 1; rec = 1; i_gnt_seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (i_gnt_seen) exp_i.push_back(rd_hash(imem_addr_i));
      i_gnt_seen = 0;
      if (k == 7) begin imem_req_i = 0; dmem_req_i = 0; mem_gnt_i = 0; rec = 0; end
    end
    mem_rvalid_i = 1; mem_rdata_i = rd_hash(32'h1000_0040);
    step(); step(); mem_rvalid_i = 0;
    check("starve_order_len", gseq.size(), 32'd8);
    for (int k = 0; k < 8 && k < gseq.size(); k++) check("starve_order", gseq[k], exp_seq[k]);

    // Held grant: owner must not switch while waiting.
    dmem_req_i = 1; dmem_we_i = 0; dmem_addr_i = 32'h2000_0300; exp_d.push_back(rd_hash(32'h2000_0300));
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin imem_req_i = 1; imem_addr_i = 32'h1000_0500; exp_i.push_back(rd_hash(32'h1000_0500)); end
      if (k == 4) mem_gnt_i = 1;
      @(negedge clk);
      check("hold_addr", mem_addr_o, 32'h2000_0300);
      check("hold_dgnt", dmem_gnt_o, (k == 4));
      step();
    end
    dmem_req_i = 0;
    step(); imem_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = rd_hash(32'h2000_0300);
    step(); mem_rdata_i = rd_hash(32'h1000_0500);
    step(); mem_rvalid_i = 0;

    // Outstanding limit: third read blocked, write still issued.
    imem_req_i = 1; imem_addr_i = 32'h1000_0010; exp_i.push_back(rd_hash(32'h1000_0010)); mem_gnt_i = 1;
    step(); imem_addr_i = 32'h1000_0020; exp_i.push_back(rd_hash(32'h1000_0020));
    step(); imem_addr_i = 32'h1000_0030; exp_i.push_back(rd_hash(32'h1000_0030));
    @(negedge clk); check("full_blocks_read", mem_req_o, 32'd0);
    step(); dmem_req_i = 1; dmem_we_i = 1; dmem_addr_i = 32'h2000_0400; dmem_wdata_i = 32'hCAFE_0001;
    @(negedge clk); check("full_write_gnt", {dmem_gnt_o, mem_we_o}, 32'd3);
    step(); dmem_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = rd_hash(32'h1000_0010);
    @(negedge clk);
    check("full_pop_no_req", mem_req_o, 32'd0);
    check("full_first_rv_imem", imem_rvalid_o, 32'd1);
    step(); mem_rdata_i = rd_hash(32'h1000_0020);
    step(); imem_req_i = 0; mem_gnt_i = 0; mem_rdata_i = rd_hash(32'h1000_0030);
    step(); mem_rvalid_i = 0;

    // Interleaved in-order returns.
    imem_req_i = 1; imem_addr_i = 32'h10; exp_i.push_back(32'hA); mem_gnt_i = 1;
    step(); imem_req_i = 0; dmem_req_i = 1; dmem_we_i = 0; dmem_addr_i = 32'h20; exp_d.push_back(32'hB);
    step(); dmem_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA;
    @(negedge clk); check("inter_imem_a", imem_rdata_o, 32'hA);
    step(); mem_rdata_i = 32'hB;
    @(negedge clk); check("inter_dmem_b", dmem_rdata_o, 32'hB);
    step(); mem_rvalid_i = 0;

    // Return with empty FIFO sets sticky error; reset clears it.
    step(); mem_rvalid_i = 1; mem_rdata_i = 32'h5555_0000;
    step(); mem_rvalid_i = 0;
    @(negedge clk); check("err_set", err_o, 32'd1);
    step(); reset_n = 0;
    @(negedge clk); check("err_cleared_in_reset", err_o, 32'd0);
    step(); reset_n = 1;
    @(negedge clk); check("err_after_reset", err_o, 32'd0);

    // Reset with a read in flight discards its tag.
    step(); imem_req_i = 1; imem_addr_i = 32'h1000_0700; mem_gnt_i = 1;
    step(); imem_req_i = 0; mem_gnt_i = 0; reset_n = 0;
    step(); reset_n = 1;
    step(); mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    @(negedge clk); check("stale_rv_dropped", {imem_rvalid_o, dmem_rvalid_o}, 32'd0);
    step(); mem_rvalid_i = 0;
    @(negedge clk); check("stale_rv_err", err_o, 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/yarp_mem_arb.md
YARP_MEM_ARB -- requirements
Module: yarp_mem_arb

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2: max reads in flight, range 1..4.
REQ-002 SHALL have parameter STARVE_MAX, default 3: consecutive dmem grants allowed while imem waits, range 1..7.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req_i / imem_addr_i  input  1/32  fetch read request, held with address stable until granted.
REQ-006 SHALL have port imem_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port imem_rvalid_o / imem_rdata_o  output  1/32  fetch read data return.
REQ-008 SHALL have port dmem_req_i / dmem_we_i / dmem_addr_i / dmem_wdata_i  input  1/1/32/32  load/store request, held stable until granted.
REQ-009 SHALL have port dmem_gnt_o / dmem_rvalid_o / dmem_rdata_o  output  1/1/32  data grant and load return.
REQ-010 SHALL have port mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  output  1/1/32/32  shared memory port request.
REQ-011 SHALL have port mem_gnt_i / mem_rvalid_i / mem_rdata_i  input  1/1/32  memory accept and in-order read return.
REQ-012 SHALL have port err_o  output  1  sticky protocol error.

Function
REQ-013 SHALL use FSM states IDLE and WAIT_GNT.
REQ-014 In IDLE with at least one request and tag FIFO not full, SHALL select an owner, drive mem_req_o=1 with that owner's fields in the same cycle (combinational), and enter WAIT_GNT if mem_gnt_i=0.
REQ-015 In WAIT_GNT, SHALL hold the selected owner and keep mem_req_o=1 until mem_gnt_i=1, with no owner switch, then return to IDLE.
REQ-016 Selection SHALL be dmem when dmem_req_i=1, unless starve_cnt==STARVE_MAX and imem_req_i=1, in which case imem is selected.
REQ-017 starve_cnt SHALL increment on each dmem grant while imem_req_i=1, saturate at STARVE_MAX, and clear on any imem grant or whenever imem_req_i=0.
REQ-018 Handshake SHALL complete on the cycle mem_req_o & mem_gnt_i; the owner's *_gnt_o SHALL be 1 for exactly that cycle, combinational from mem_gnt_i.
REQ-019 mem_we_o SHALL equal dmem_we_i when dmem is owner and 0 when imem is owner; mem_wdata_o SHALL be 0 when imem is owner.
REQ-020 Each granted read SHALL push its owner ID into the tag FIFO; writes SHALL NOT push.
REQ-021 On mem_rvalid_i, SHALL pop the FIFO and route mem_rdata_i to the popped owner's *_rvalid_o/*_rdata_o combinationally (zero latency); the other rvalid SHALL stay 0.
REQ-022 *_rdata_o SHALL be 0 when the corresponding *_rvalid_o is 0.
REQ-023 When the FIFO holds OUTSTANDING entries, SHALL NOT start a new request (mem_req_o=0 from IDLE), even if a pop occurs the same cycle; a request already in WAIT_GNT when full SHALL be impossible, as the full check gates IDLE entry only when a read is selected; writes SHALL be issued regardless of full.
REQ-024 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-025 mem_rvalid_i with an empty FIFO SHALL set err_o, route nothing, and leave the FIFO unchanged.
REQ-026 Count and pointer arithmetic SHALL wrap modulo OUTSTANDING using a clog2-sized pointer plus a separate occupancy count.

Reset
REQ-027 On reset_n=0, SHALL asynchronously enter IDLE, empty the FIFO, clear starve_cnt, and clear err_o.
REQ-028 During reset, all outputs SHALL be 0.
REQ-029 Reset mid-transaction SHALL discard outstanding tags; responses arriving after reset SHALL flag err_o.

Structure
REQ-030 yarp_pkg SHALL hold typedef mem_owner_t {OWN_IMEM, OWN_DMEM} and typedef arb_state_t {ARB_IDLE, ARB_WAIT_GNT}.
REQ-031 The tag FIFO SHALL be the sub-module yarp_tag_fifo (parameter DEPTH; push, pop, din, dout, full, empty).

Verification
REQ-032 Only imem requests addr 0x100, gnt same cycle, rvalid next cycle with 0xDEADBEEF -> imem_gnt_o=1 at cycle 0, imem_rvalid_o=1 with 0xDEADBEEF at cycle 1, dmem_rvalid_o=0.
REQ-033 Both request continuously with mem_gnt_i=1 and STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I.
REQ-034 dmem request with mem_gnt_i held 0 for 4 cycles, imem request arriving at cycle 1 -> mem_addr_o stays at the dmem address and dmem_gnt_o=1 only at cycle 4.
REQ-035 OUTSTANDING=2, two imem reads granted with no rvalid -> mem_req_o=0 for a third read; a dmem write is still issued; the first rvalid returns to imem.
REQ-036 Interleaved reads I(0x10), D(0x20) returned in order with 0xA, 0xB -> imem_rdata_o=0xA then dmem_rdata_o=0xB.
REQ-037 mem_rvalid_i pulsed with empty FIFO, then reset_n pulsed low -> err_o=1 after the pulse, 0 after reset.
